fp_accumulator: RTL and testbench
=================================

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the optional product counter (Configuration).
REQ-002 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port clear  input  1: synchronous abort; zeroes the sum and returns to IDLE.
REQ-005 SHALL have port in_valid  input  1: in_data is presented this cycle.
REQ-006 SHALL have port in_ready  output  1: block can accept in_data this cycle.
REQ-007 SHALL have port in_data  input  32: FP32 product from the upstream multiplier.
REQ-008 SHALL have port in_last  input  1: qualifies the accepted product as the last of its batch.
REQ-009 SHALL have port out_valid  output  1: out_data holds the finished batch sum.
REQ-010 SHALL have port out_ready  input  1: the consumer takes out_data.
REQ-011 SHALL have port out_data  output  32: FP32 accumulated sum.

Function
REQ-012 SHALL implement the FSM states IDLE, ALIGN, ADD, NORM and DONE.
REQ-013 SHALL assert in_ready only in IDLE.
REQ-014 SHALL accept a product when in_valid and in_ready are both high, and SHALL latch in_data and in_last on that edge.
REQ-015 SHALL transition IDLE->ALIGN on acceptance, then ALIGN->ADD->NORM on successive edges, then NORM->DONE if the latched last bit is set, else NORM->IDLE.
REQ-016 SHALL give a throughput of one product per 4 cycles; in_ready is high again in the first cycle after NORM.
REQ-017 In ALIGN, SHALL right-shift the smaller-exponent 24-bit significand (with hidden 1) by the exponent difference, truncating shifted-out bits; a shift of 24 or more yields 0.
REQ-018 In ADD, SHALL add the magnitudes when the signs are equal and subtract smaller from larger when they differ; the result sign is the sign of the larger magnitude.
REQ-019 In NORM, on carry-out SHALL shift right 1 with exponent +1; otherwise SHALL left-shift by the leading-zero count with exponent minus that count, then write the sum register.
REQ-020 SHALL treat any operand with exponent 0 as zero (denormals flushed); exponent 255 has no special handling.
REQ-021 SHALL produce +0 (0x00000000) on exact cancellation or exponent underflow.
REQ-022 SHALL clamp exponent overflow to the signed maximum finite value (0x7F7FFFFF or 0xFF7FFFFF).
REQ-023 SHALL hold out_valid high in DONE, with out_data equal to the sum register and stable until out_ready is high.
REQ-024 On DONE with out_ready high, SHALL clear the sum to +0 and go to IDLE; out_valid is low on the next cycle.
REQ-025 SHALL hold out_valid low in all states except DONE.
REQ-026 SHALL give clear priority over in_valid and out_ready in every state; on that edge the sum becomes +0, the state becomes IDLE and any in-flight product is discarded.

Reset
REQ-027 With rst high on a clock edge, SHALL set state IDLE, sum +0, latched operands 0, in_ready 1 in the following cycle, out_valid 0 and out_data 0x00000000.
REQ-028 SHALL give rst priority over clear and all other inputs, including when asserted mid-operation (ALIGN/ADD/NORM/DONE).

Configuration
REQ-029 With macro FP_ACC_COUNT_EN defined, SHALL add output out_count (CNT_W bits) holding the number of products accepted in the current batch.
REQ-030 out_count SHALL saturate at all-ones, be valid in DONE, and return to 0 on rst, clear or the DONE handshake.
REQ-031 Without FP_ACC_COUNT_EN, the out_count port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: accept 0x3F800000, then 0x40000000 with in_last -> out_valid high 4 cycles after the second accept, out_data 0x40400000.
REQ-033 SHALL cover: 0x40400000 then 0xC0400000 with in_last -> out_data 0x00000000.
REQ-034 SHALL cover: single 0xC0A00000 with in_last, out_ready held low 5 cycles -> out_data stays 0xC0A00000 and out_valid stays high; the handshake is followed by out_valid 0 and in_ready 1.
REQ-035 SHALL cover: 0x7F7FFFFF then 0x7F7FFFFF with in_last -> out_data 0x7F7FFFFF.
REQ-036 SHALL cover: clear asserted in ADD -> IDLE next cycle; a following 0x3F800000 with in_last -> out_data 0x3F800000.
REQ-037 SHALL cover: with FP_ACC_COUNT_EN, 3 products then last -> out_count 4 in DONE, and 0 after the handshake.

Source files
------------

// File: rtl/fp_accumulator.sv
// FP32 batch accumulator: sums a stream of FP32 products, one batch per in_last.
// Latency: 4 cycles from accept to sum update (IDLE, ALIGN, ADD, NORM); the batch result appears in DONE.
// Backpressure: in_ready only in IDLE; DONE holds out_valid/out_data until out_ready. Optional FP_ACC_COUNT_EN adds out_count.
module fp_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data
`ifdef FP_ACC_COUNT_EN
   ,
   output logic [CNT_W-1:0]  out_count
`endif
);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t      state;
   logic [31:0] sum;
   logic [31:0] op_data;
   logic        op_last;

   // ALIGN stage registers: a is the larger-exponent operand, b is already shifted
   logic [23:0] a_mant, b_mant;
   logic [7:0]  a_exp;
   logic        a_sign, b_sign;

   // ADD stage registers: unnormalised magnitude with carry bit
   logic [24:0] add_mag;
   logic [7:0]  add_exp;
   logic        add_sign;

   // combinational next values for each stage
   logic [7:0]  s_exp, o_exp, exp_diff;
   logic [23:0] s_mant, o_mant, al_a_mant, al_b_src, al_b_mant;
   logic [7:0]  al_exp;
   logic        al_a_sign, al_b_sign, sum_big;
   logic [24:0] ad_mag;
   logic        ad_sign;
   logic [4:0]  lz;
   logic [9:0]  exp_up, exp_dn;
   logic [23:0] norm_mant;
   logic [31:0] norm_sum;

   // leading-zero count of a 24-bit significand; the highest set bit wins
   function automatic logic [4:0] lzc24(input logic [23:0] v);
      lzc24 = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (v[i]) lzc24 = 5'(23 - i);
      end
   endfunction

   assign out_data = sum;

   // ALIGN: pick the larger exponent and right-shift the other significand (denormals read as zero)
   always_comb begin
      s_exp     = sum[30:23];
      o_exp     = op_data[30:23];
      s_mant    = (s_exp == 8'd0) ? 24'd0 : {1'b1, sum[22:0]};
      o_mant    = (o_exp == 8'd0) ? 24'd0 : {1'b1, op_data[22:0]};
      sum_big   = (s_exp >= o_exp);
      exp_diff  = sum_big ? (s_exp - o_exp) : (o_exp - s_exp);
      al_a_mant = sum_big ? s_mant : o_mant;
      al_b_src  = sum_big ? o_mant : s_mant;
      al_a_sign = sum_big ? sum[31] : op_data[31];
      al_b_sign = sum_big ? op_data[31] : sum[31];
      al_exp    = sum_big ? s_exp : o_exp;
      al_b_mant = (exp_diff >= 8'd24) ? 24'd0 : (al_b_src >> exp_diff);
   end

   // ADD: magnitude add on equal signs, else larger minus smaller taking the larger's sign
   always_comb begin
      ad_mag  = 25'd0;
      ad_sign = a_sign;
      if (a_sign == b_sign) begin
         ad_mag  = {1'b0, a_mant} + {1'b0, b_mant};
         ad_sign = a_sign;
      end else if (a_mant >= b_mant) begin
         ad_mag  = {1'b0, a_mant} - {1'b0, b_mant};
         ad_sign = a_sign;
      end else begin
         ad_mag  = {1'b0, b_mant} - {1'b0, a_mant};
         ad_sign = b_sign;
      end
   end

   // NORM: carry shifts right, otherwise shift out leading zeros; cancellation/underflow give +0, overflow clamps
   always_comb begin
      lz        = lzc24(add_mag[23:0]);
      exp_up    = {2'b00, add_exp} + 10'd1;
      exp_dn    = {2'b00, add_exp} - {5'd0, lz};
      norm_mant = add_mag[23:0] << lz;
      norm_sum  = 32'h0000_0000;
      if (add_mag == 25'd0) begin
         norm_sum = 32'h0000_0000;
      end else if (add_mag[24]) begin
         if (exp_up > 10'd254)
            norm_sum = {add_sign, 8'hFE, 23'h7F_FFFF};
         else
            norm_sum = {add_sign, exp_up[7:0], add_mag[23:1]};
      end else if (exp_dn[9] || (exp_dn == 10'd0)) begin
         norm_sum = 32'h0000_0000;
      end else begin
         norm_sum = {add_sign, exp_dn[7:0], norm_mant[22:0]};
      end
   end

   // control FSM with registered handshake outputs; rst beats clear beats everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sum       <= 32'h0000_0000;
         op_data   <= 32'h0000_0000;
         op_last   <= 1'b0;
         a_mant    <= 24'd0;
         b_mant    <= 24'd0;
         a_exp     <= 8'd0;
         a_sign    <= 1'b0;
         b_sign    <= 1'b0;
         add_mag   <= 25'd0;
         add_exp   <= 8'd0;
         add_sign  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef FP_ACC_COUNT_EN
         out_count <= '0;
`endif
      end else if (clear) begin
         state     <= IDLE;
         sum       <= 32'h0000_0000;
         op_last   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef FP_ACC_COUNT_EN
         out_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_data  <= in_data;
                  op_last  <= in_last;
                  in_ready <= 1'b0;
                  state    <= ALIGN;
`ifdef FP_ACC_COUNT_EN
                  if (out_count != {CNT_W{1'b1}})
                     out_count <= out_count + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
               end
            end
            ALIGN: begin
               a_mant <= al_a_mant;
               b_mant <= al_b_mant;
               a_exp  <= al_exp;
               a_sign <= al_a_sign;
               b_sign <= al_b_sign;
               state  <= ADD;
            end
            ADD: begin
               add_mag  <= ad_mag;
               add_exp  <= a_exp;
               add_sign <= ad_sign;
               state    <= NORM;
            end
            NORM: begin
               sum <= norm_sum;
               if (op_last) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  sum       <= 32'h0000_0000;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
`ifdef FP_ACC_COUNT_EN
                  out_count <= '0;
`endif
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: hand-computed FP32 sums, latency, backpressure, clear and reset.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Every wait on the DUT is bounded; a timeout counts as a failed check.
module tb_fp_accumulator;

   logic        clk = 1'b0;
   logic        rst, clear, in_valid, in_last, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
`ifdef FP_ACC_COUNT_EN
   logic [7:0]  out_count;
`endif

   int checks = 0;
   int errors = 0;
   int lat;

   fp_accumulator #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef FP_ACC_COUNT_EN
      ,
      .out_count (out_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // wait (bounded) for in_ready, present one product for exactly one accepting edge
   task automatic send(input logic [31:0] d, input logic last);
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check("send_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 32'h0;
   endtask

   // called one cycle after an accept edge: count cycles since the accept until out_valid
   task automatic wait_done(output int l);
      l = 1;
      while (!out_valid && l < 20) begin
         step();
         l++;
      end
      check("done_wait", {31'd0, out_valid}, 32'd1);
   endtask

   // complete the output handshake and confirm the block is ready again
   task automatic take(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b0; in_data = 32'h0;
      step();
      step();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'h0000_0000);
      rst = 1'b0;
      step();

      // 1.0 + 2.0 = 3.0, with throughput and result latency
      send(32'h3F80_0000, 1'b0);
      lat = 1;
      while (!in_ready && lat < 20) begin
         step();
         lat++;
      end
      check("throughput_cycles", lat, 32'd4);
      check("partial_sum", out_data, 32'h3F80_0000);
      send(32'h4000_0000, 1'b1);
      wait_done(lat);
      check("done_latency", lat, 32'd4);
      check("sum_1p2", out_data, 32'h4040_0000);
      check("ready_low_in_done", {31'd0, in_ready}, 32'd0);
      take("sum_1p2");
      check("sum_cleared_after_take", out_data, 32'h0000_0000);

      // 3.0 + -3.0: exact cancellation
      send(32'h4040_0000, 1'b0);
      send(32'hC040_0000, 1'b1);
      wait_done(lat);
      check("cancel", out_data, 32'h0000_0000);
      take("cancel");

      // single -5.0 with output stalled for 5 cycles
      send(32'hC0A0_0000, 1'b1);
      wait_done(lat);
      for (int i = 0; i < 5; i++) begin
         check("stall_data", out_data, 32'hC0A0_0000);
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         step();
      end
      take("stall");

      // max finite + max finite clamps
      send(32'h7F7F_FFFF, 1'b0);
      send(32'h7F7F_FFFF, 1'b1);
      wait_done(lat);
      check("pos_overflow", out_data, 32'h7F7F_FFFF);
      take("pos_overflow");
      send(32'hFF7F_FFFF, 1'b0);
      send(32'hFF7F_FFFF, 1'b1);
      wait_done(lat);
      check("neg_overflow", out_data, 32'hFF7F_FFFF);
      take("neg_overflow");

      // 3.0 + -1.0 = 2.0 (subtract, larger first)
      send(32'h4040_0000, 1'b0);
      send(32'hBF80_0000, 1'b1);
      wait_done(lat);
      check("sub_3m1", out_data, 32'h4000_0000);
      take("sub_3m1");

      // 1.0 + -3.0 = -2.0 (new operand has larger magnitude)
      send(32'h3F80_0000, 1'b0);
      send(32'hC040_0000, 1'b1);
      wait_done(lat);
      check("sub_1m3", out_data, 32'hC000_0000);
      take("sub_1m3");

      // 2.0 + -1.5 = 0.5 (left normalisation by 2)
      send(32'h4000_0000, 1'b0);
      send(32'hBFC0_0000, 1'b1);
      wait_done(lat);
      check("norm_left", out_data, 32'h3F00_0000);
      take("norm_left");

      // 1.0 + 2^24: shift of 24 drops the small operand
      send(32'h3F80_0000, 1'b0);
      send(32'h4B80_0000, 1'b1);
      wait_done(lat);
      check("shift24", out_data, 32'h4B80_0000);
      take("shift24");

      // denormal operand is flushed to zero
      send(32'h0040_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      wait_done(lat);
      check("denorm_flush", out_data, 32'h3F80_0000);
      take("denorm_flush");

      // clear in ADD discards the batch
      send(32'h4000_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_in_ready", {31'd0, in_ready}, 32'd1);
      check("clear_out_valid", {31'd0, out_valid}, 32'd0);
      check("clear_sum", out_data, 32'h0000_0000);
      send(32'h3F80_0000, 1'b1);
      wait_done(lat);
      check("after_clear", out_data, 32'h3F80_0000);
      take("after_clear");

      // reset in ADD overrides clear and the in-flight product
      send(32'h4000_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      step();
      rst = 1'b1;
      clear = 1'b1;
      step();
      rst = 1'b0;
      clear = 1'b0;
      check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
      check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_data", out_data, 32'h0000_0000);
      send(32'hC0A0_0000, 1'b1);
      wait_done(lat);
      check("after_rst", out_data, 32'hC0A0_0000);
      take("after_rst");

`ifdef FP_ACC_COUNT_EN
      // four 1.0 products: count 4, sum 4.0
      check("count_idle", {24'd0, out_count}, 32'd0);
      for (int i = 0; i < 3; i++) send(32'h3F80_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      wait_done(lat);
      check("count_done", {24'd0, out_count}, 32'd4);
      check("count_sum", out_data, 32'h4080_0000);
      take("count");
      check("count_after", {24'd0, out_count}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
